cordic_vector_clocked: RTL and testbench
========================================

Name: cordic_vector_clocked

Overview:
- Iterative CORDIC in vectoring mode; the inverse of the rotation-mode sin/cos units.
- Takes a Cartesian vector (x, y) and returns its magnitude and its angle atan2(y, x).
- Performs one micro-rotation per clock and uses a valid/ready handshake on both input and output.
- Feeds phase/magnitude recovery in the same datapath as the sin/cos generators, using the same 32-bit fixed-point format.

Parameters:
- TERMS, 16, number of micro-rotation iterations. Legal range 8..31.
- FRAC, 29, fractional bits of every data word (signed Q2.29).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  x_in/y_in valid.
- in_ready  output  1  block can accept a vector.
- x_in  input  32  signed Q2.29 x; |x_in| <= 1.0 (0x20000000).
- y_in  input  32  signed Q2.29 y; |y_in| <= 1.0.
- out_valid  output  1  mag_out/angle_out valid.
- out_ready  input  1  consumer accepts the result.
- mag_out  output  32  signed Q2.29 sqrt(x^2+y^2), gain-compensated.
- angle_out  output  32  signed Q2.29 radians, range (-pi, +pi].

Behaviour:
- Reset values:
  - State IDLE, in_ready=1, out_valid=0.
  - mag_out=0, angle_out=0, iteration counter=0.
  - All internal x/y/z registers cleared.
- States: IDLE, ITER, SCALE, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid is high at a clock edge, the vector is captured and the state moves to ITER.
  - Quadrant pre-rotation is applied combinationally at capture:
    - x_in >= 0: x0=x_in, y0=y_in, z0=0.
    - x_in < 0 and y_in >= 0: x0=y_in, y0=-x_in, z0=+pi/2 (843314857).
    - x_in < 0 and y_in < 0: x0=-y_in, y0=x_in, z0=-pi/2.
  - zero_flag is registered as (x_in==0 && y_in==0).
- ITER, iteration i = 0..TERMS-1, one per cycle:
  - If y >= 0: x += y>>>i; y -= x>>>i; z += atan[i].
  - Else: x -= y>>>i; y += x>>>i; z -= atan[i].
  - All updates use the old x/y values and arithmetic shifts.
  - atan[i] = round(atan(2^-i) * 2^29) as constants; atan[0]=421657428.
  - After iteration TERMS-1, go to SCALE.
- SCALE:
  - mag = (x_final * GAIN_INV) >>> 29, using a 64-bit signed product truncated to 32 bits.
  - GAIN_INV = 326016437 (0.607252935 in Q2.29). This value is used for all TERMS.
  - angle = zero_flag ? 0 : z_final.
  - mag_out and angle_out are registered; go to DONE.
- DONE:
  - out_valid=1; mag_out and angle_out are held stable.
  - On out_ready high at a clock edge: out_valid drops to 0 and the state returns to IDLE.
- in_ready is low in ITER, SCALE and DONE. in_valid is ignored while in_ready=0; no queuing.
- Latency and throughput:
  - out_valid rises TERMS+1 cycles after the accepting edge.
  - Minimum acceptance spacing is TERMS+3 cycles when out_ready is held high.
  - A new input is never accepted in the same cycle as an output handshake.
- Width safety: with the input range limit, internal |x| < 2.33, so no overflow occurs in Q2.29. Behaviour outside the input range is undefined.
- Boundaries:
  - (-1.0, 0) yields approximately +pi, never -pi.
  - (0, 0) yields mag=0, angle=0.
  - Asserting rst in any state aborts the operation immediately and restores all reset values.
- Accuracy for TERMS=16:
  - angle within 32768 LSB (2^-14 rad) of the ideal value.
  - mag within 2^-14 relative error plus 4 LSB.

Test Plan:
- (0x20000000, 0) -> mag ≈ 536870912, angle ≈ 0; out_valid exactly 17 cycles after acceptance.
- (0x10000000, 0x10000000) -> mag ≈ 379625062 (0.7071), angle ≈ 421657428 (pi/4), within tolerance.
- (0xE0000000, 0) -> mag ≈ 536870912, angle ≈ +1686629713 (+pi). (0, 0xF0000000) -> mag ≈ 268435456, angle ≈ -843314857.
- (0, 0) -> mag=0, angle=0 exactly.
- Backpressure: out_ready held low 5 cycles after out_valid -> outputs stable and in_ready=0 throughout. in_valid pulsed with a different vector during ITER -> ignored; the result matches the first vector.
- rst asserted mid-ITER (iteration 7) -> on the same edge in_ready=1 and out_valid=0. A new vector accepted afterwards gives the correct result with no residue from the aborted operation.

Source files
------------

// File: rtl/cordic_vector_clocked.sv
// rtl/cordic_vector_clocked.sv - iterative vectoring-mode CORDIC: (x, y) -> magnitude, atan2(y, x)
module cordic_vector_clocked #(
    parameter int TERMS = 16,
    parameter int FRAC  = 29
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x_in,
    input  logic [31:0] y_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] mag_out,
    output logic [31:0] angle_out
);

    // Angle constants are Q2.29 radians; the arctangent table is built for 29 fractional bits.
    localparam logic signed [31:0] HALF_PI  = 32'sd843314857;
    localparam logic signed [31:0] GAIN_INV = 32'sd326016437;
    localparam logic [4:0]         LAST     = 5'(TERMS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        SCALE,
        DONE
    } state_t;

    state_t             state;
    logic [4:0]         cnt;
    logic signed [31:0] x;
    logic signed [31:0] y;
    logic signed [31:0] z;
    logic               zero_flag;

    logic signed [31:0] x0;
    logic signed [31:0] y0;
    logic signed [31:0] z0;
    logic signed [31:0] xs;
    logic signed [31:0] ys;
    logic signed [31:0] atan_i;
    logic signed [63:0] prod;
    logic signed [31:0] mag_next;

    // round(atan(2^-i) * 2^29); beyond i=29 the angle rounds to zero.
    function automatic logic signed [31:0] atan_lut(input logic [4:0] idx);
        case (idx)
            5'd0:    atan_lut = 32'sd421657428;
            5'd1:    atan_lut = 32'sd248918915;
            5'd2:    atan_lut = 32'sd131521918;
            5'd3:    atan_lut = 32'sd66762579;
            5'd4:    atan_lut = 32'sd33510843;
            5'd5:    atan_lut = 32'sd16771758;
            5'd6:    atan_lut = 32'sd8387925;
            5'd7:    atan_lut = 32'sd4194219;
            5'd8:    atan_lut = 32'sd2097141;
            5'd9:    atan_lut = 32'sd1048575;
            5'd10:   atan_lut = 32'sd524288;
            5'd11:   atan_lut = 32'sd262144;
            5'd12:   atan_lut = 32'sd131072;
            5'd13:   atan_lut = 32'sd65536;
            5'd14:   atan_lut = 32'sd32768;
            5'd15:   atan_lut = 32'sd16384;
            5'd16:   atan_lut = 32'sd8192;
            5'd17:   atan_lut = 32'sd4096;
            5'd18:   atan_lut = 32'sd2048;
            5'd19:   atan_lut = 32'sd1024;
            5'd20:   atan_lut = 32'sd512;
            5'd21:   atan_lut = 32'sd256;
            5'd22:   atan_lut = 32'sd128;
            5'd23:   atan_lut = 32'sd64;
            5'd24:   atan_lut = 32'sd32;
            5'd25:   atan_lut = 32'sd16;
            5'd26:   atan_lut = 32'sd8;
            5'd27:   atan_lut = 32'sd4;
            5'd28:   atan_lut = 32'sd2;
            5'd29:   atan_lut = 32'sd1;
            default: atan_lut = 32'sd0;
        endcase
    endfunction

    // Fold left-half-plane vectors into the right half plane so the iterations always converge.
    always_comb begin
        x0 = $signed(x_in);
        y0 = $signed(y_in);
        z0 = 32'sd0;
        if (x_in[31]) begin
            if (!y_in[31]) begin
                x0 = $signed(y_in);
                y0 = -$signed(x_in);
                z0 = HALF_PI;
            end else begin
                x0 = -$signed(y_in);
                y0 = $signed(x_in);
                z0 = -HALF_PI;
            end
        end
    end

    // Shifted operands, table angle and gain-compensated magnitude for the current step.
    always_comb begin
        xs       = x >>> cnt;
        ys       = y >>> cnt;
        atan_i   = atan_lut(cnt);
        prod     = 64'(x) * 64'(GAIN_INV);
        mag_next = 32'(prod >>> FRAC);
    end

    // Control FSM and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            x         <= 32'sd0;
            y         <= 32'sd0;
            z         <= 32'sd0;
            zero_flag <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            mag_out   <= 32'd0;
            angle_out <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x         <= x0;
                        y         <= y0;
                        z         <= z0;
                        zero_flag <= (x_in == 32'd0) && (y_in == 32'd0);
                        cnt       <= 5'd0;
                        in_ready  <= 1'b0;
                        state     <= ITER;
                    end
                end
                ITER: begin
                    // Drive y toward zero; z accumulates the rotated angle.
                    if (!y[31]) begin
                        x <= x + ys;
                        y <= y - xs;
                        z <= z + atan_i;
                    end else begin
                        x <= x - ys;
                        y <= y + xs;
                        z <= z - atan_i;
                    end
                    if (cnt == LAST) begin
                        cnt   <= 5'd0;
                        state <= SCALE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                SCALE: begin
                    mag_out   <= mag_next;
                    angle_out <= zero_flag ? 32'd0 : z;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vector_clocked.sv
// tb/tb_cordic_vector_clocked.sv - scoreboard bench for cordic_vector_clocked
module tb_cordic_vector_clocked;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x_in;
    logic [31:0] y_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] mag_out;
    logic [31:0] angle_out;

    cordic_vector_clocked #(.TERMS(16), .FRAC(29)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag_out   (mag_out),
        .angle_out (angle_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] mag;
        logic [31:0] ang;
        longint      mtol;
        longint      atol;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec   = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    logic ov_prev = 1'b0;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req,
                             input longint tol);
        longint d;
        d = longint'($signed(act)) - longint'($signed(req));
        if (d < 0) d = -d;
        n_vec++;
        if (d > tol) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (tol %0d)", name, $signed(act), $signed(req), tol);
        end
    endtask

    function automatic longint mag_tol(input logic [31:0] m);
        return longint'($signed(m)) / 16384 + 4;
    endfunction

    // Cycle counter and acceptance timestamp.
    always @(posedge clk) begin
        if (in_valid && in_ready) acc_cyc <= cyc;
        cyc <= cyc + 1;
    end

    // Monitor: latency on rising out_valid, scoreboard compare on each output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev)
                check_val("latency", 32'(cyc - 1 - acc_cyc), 32'd17, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_output: got mag %0d angle %0d, required no output",
                             $signed(mag_out), $signed(angle_out));
                end else begin
                    e = exp_q.pop_front();
                    check_val("mag", mag_out, e.mag, e.mtol);
                    check_val("angle", angle_out, e.ang, e.atol);
                end
            end
            ov_prev = out_valid;
        end
    end

    task automatic send(input logic [31:0] xv, input logic [31:0] yv, input logic [31:0] em,
                        input logic [31:0] ea, input bit exact);
        exp_t e;
        int   guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready 0, required 1");
            return;
        end
        e.mag  = em;
        e.ang  = ea;
        e.mtol = exact ? 0 : mag_tol(em);
        e.atol = exact ? 0 : 32768;
        exp_q.push_back(e);
        x_in     = xv;
        y_in     = yv;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int guard;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x_in      = 32'd0;
        y_in      = 32'd0;
        repeat (2) @(negedge clk);
        check_val("rst_in_ready", 32'(in_ready), 32'd1, 0);
        check_val("rst_out_valid", 32'(out_valid), 32'd0, 0);
        check_val("rst_mag", mag_out, 32'd0, 0);
        check_val("rst_angle", angle_out, 32'd0, 0);
        rst = 1'b0;

        send(32'h2000_0000, 32'h0000_0000, 32'd536870912, 32'd0, 1'b0);
        drain();
        send(32'h1000_0000, 32'h1000_0000, 32'd379625062, 32'd421657428, 1'b0);
        drain();
        send(32'hE000_0000, 32'h0000_0000, 32'd536870912, 32'd1686629713, 1'b0);
        drain();
        send(32'h0000_0000, 32'hF000_0000, 32'd268435456, -32'sd843314857, 1'b0);
        drain();
        // Back-to-back: zero vector then +pi/2.
        send(32'h0000_0000, 32'h0000_0000, 32'd0, 32'd0, 1'b1);
        send(32'h0000_0000, 32'h2000_0000, 32'd536870912, 32'd843314857, 1'b0);
        drain();

        // Backpressure: hold out_ready low for 5 cycles after out_valid.
        out_ready = 1'b0;
        send(32'hF000_0000, 32'hF000_0000, 32'd379625062, -32'sd1264972285, 1'b0);
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("hold_out_valid", 32'(out_valid), 32'd1, 0);
            check_val("hold_in_ready", 32'(in_ready), 32'd0, 0);
            if (exp_q.size() != 0) begin
                check_val("hold_mag", mag_out, exp_q[0].mag, exp_q[0].mtol);
                check_val("hold_angle", angle_out, exp_q[0].ang, exp_q[0].atol);
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // in_valid pulsed with another vector during ITER must be ignored.
        send(32'h1000_0000, 32'h1000_0000, 32'd379625062, 32'd421657428, 1'b0);
        x_in     = 32'hE000_0000;
        y_in     = 32'h0000_0000;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val("iter_in_ready", 32'(in_ready), 32'd0, 0);
        end
        in_valid = 1'b0;
        drain();

        // Reset during iteration 7 aborts the operation.
        send(32'hE000_0000, 32'h1000_0000, 32'd0, 32'd0, 1'b0);
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        void'(exp_q.pop_back());
        #1;
        check_val("abort_in_ready", 32'(in_ready), 32'd1, 0);
        check_val("abort_out_valid", 32'(out_valid), 32'd0, 0);
        check_val("abort_mag", mag_out, 32'd0, 0);
        check_val("abort_angle", angle_out, 32'd0, 0);
        @(negedge clk);
        rst = 1'b0;
        send(32'h1000_0000, 32'hF000_0000, 32'd379625062, -32'sd421657428, 1'b0);
        drain();

        repeat (30) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
